div_result_display: RTL and testbench
=====================================

Name: div_result_display

Overview:
- Downstream stage of the 4-bit restoring divider.
- Captures the divider's Quotient/Remainder when the result is valid, then converts each value to two BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Drives four active-low seven-segment displays.
- Quotient is shown on HEX1:HEX0 (tens:ones) and Remainder on HEX3:HEX2.

Parameters:
- WIDTH, 4, operand width of Quotient/Remainder. Legal range 4..6, so the maximum value of 63 always fits two BCD digits.

Ports:
- Clock  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  single-cycle strobe: Quotient/Remainder are valid this cycle
- Quotient  input  WIDTH  unsigned divider quotient
- Remainder  input  WIDTH  unsigned divider remainder
- Busy  output  1  conversion in progress; InValid is not accepted while high
- Overrun  output  1  sticky: InValid arrived while Busy
- HEX0  output  7  quotient ones digit, segments {g,f,e,d,c,b,a}, active-low
- HEX1  output  7  quotient tens digit
- HEX2  output  7  remainder ones digit
- HEX3  output  7  remainder tens digit

Behaviour:
- Reset (async, active-high, any state): state=IDLE, Busy=0, Overrun=0, HEX0..HEX3=7'b1111111 (blank), shift registers and counter cleared. A reset mid-conversion aborts it; displays go blank immediately.
- States:
  - IDLE: waits for InValid. When InValid=1 at edge k, latch {8'b0, Quotient} and {8'b0, Remainder} into two (8+WIDTH)-bit shift registers, load count=WIDTH, go to SHIFT.
  - SHIFT: one step per cycle, both values in parallel. Each BCD nibble >=5 gets +3, then the whole register shifts left 1; count decrements. After WIDTH steps go to UPDATE.
  - UPDATE: copy the four BCD nibbles through the seven-segment decode into the HEX output registers, then go to IDLE.
- Latency: InValid accepted at edge k; HEX outputs change at edge k+WIDTH+2 (6 for WIDTH=4).
- Busy is registered: it is 1 from edge k to edge k+WIDTH+2 and 0 in IDLE. A new InValid is accepted in the same cycle Busy falls.
- InValid while Busy=1: the request is ignored, the in-flight conversion is unaffected, and Overrun is set to 1. Overrun clears only on Reset.
- HEX outputs hold their last value between conversions. Nothing is combinational from the inputs to HEX.
- Quotient/Remainder are sampled only at acceptance and may change freely afterwards.
- Digit decode: 0..9 use the standard active-low patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 5=0010010, 9=0010000). Any nibble >9 is impossible by construction; it decodes to blank.

Optional Feature:
- Macro: DIV_DISPLAY_LEADING_BLANK_EN
- Defined: HEX1/HEX3 show blank (7'b1111111) when their tens digit is 0.
- Undefined: tens digits always display, including 0 (7'b1000000).
- Latency and every other behaviour are identical in both builds.

Decomposition:
- Package div_display_pkg holds:
  - state enum {IDLE, SHIFT, UPDATE}
  - SEG_BLANK constant
  - a 10-entry digit-pattern constant table
  - BCD_W=8
- Sub-module: seg7_decode, a combinational 4-bit BCD to 7-bit active-low decoder, instantiated four times.

Test Plan:
- Reset then idle with no strobe -> HEX0..3=7'b1111111, Busy=0, Overrun=0.
- Quotient=13, Remainder=2, InValid pulse -> Busy high for 6 edges, then HEX1=1111001, HEX0=0110000, HEX2=0100100; HEX3=1000000 (macro off) or 1111111 (macro on).
- Quotient=15, Remainder=0, then Quotient=0, Remainder=9 back-to-back on the cycle Busy falls -> first shows 1/5 and 0/0, second accepted with no Overrun and shows 0/0 and 0/9.
- InValid pulsed twice during one conversion with different operands -> displays show only the first operands; Overrun=1 and stays 1 until Reset.
- Reset asserted at SHIFT step 2 -> outputs blank immediately; after release a new InValid with Quotient=7, Remainder=3 converts correctly.
- Exhaustive sweep Quotient, Remainder = 0..15 -> decoded HEX digits match the decimal value on every case.

Source files
------------

// File: rtl/div_display_pkg.sv
// Shared types and constants for the divider result display: FSM states,
// seven-segment patterns and the BCD add-3 adjustment used by double-dabble.
package div_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int BCD_W = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns, element n is digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = {BCD_W{1'b0}};
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/div_result_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes above 9 cannot occur from the converter and decode to blank.
module seg7_decode
    import div_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup with a blank fallback for non-BCD codes.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/div_result_display.sv
// Captures divider Quotient/Remainder, converts both to BCD by double-dabble and
// drives four seven-segment displays. Build option: DIV_DISPLAY_LEADING_BLANK_EN.
module div_result_display
    import div_display_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    input  logic [WIDTH-1:0] Quotient,
    input  logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Overrun,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int SR_W = BCD_W + WIDTH;

    state_t          state_r, state_s;
    logic [SR_W-1:0] q_sr_r, q_sr_s;
    logic [SR_W-1:0] r_sr_r, r_sr_s;
    logic [2:0]      count_r, count_s;
    logic            busy_s, overrun_s;
    logic [6:0]      hex0_s, hex1_s, hex2_s, hex3_s;

    logic [3:0]      q_tens_s, q_ones_s, r_tens_s, r_ones_s;
    logic [6:0]      seg_q_tens_s, seg_q_ones_s, seg_r_tens_s, seg_r_ones_s;
    logic [6:0]      disp_q_tens_s, disp_r_tens_s;

    // One double-dabble step: adjust the BCD field, then shift the register left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [BCD_W-1:0] adj;
        adj = bcd_adjust(sr[SR_W-1 -: BCD_W]);
        return {adj[BCD_W-2:0], sr[WIDTH-1:0], 1'b0};
    endfunction

    assign q_tens_s = q_sr_r[SR_W-1 -: 4];
    assign q_ones_s = q_sr_r[SR_W-5 -: 4];
    assign r_tens_s = r_sr_r[SR_W-1 -: 4];
    assign r_ones_s = r_sr_r[SR_W-5 -: 4];

    seg7_decode u_dec_q_ones (.digit(q_ones_s), .seg(seg_q_ones_s));
    seg7_decode u_dec_q_tens (.digit(q_tens_s), .seg(seg_q_tens_s));
    seg7_decode u_dec_r_ones (.digit(r_ones_s), .seg(seg_r_ones_s));
    seg7_decode u_dec_r_tens (.digit(r_tens_s), .seg(seg_r_tens_s));

`ifdef DIV_DISPLAY_LEADING_BLANK_EN
    assign disp_q_tens_s = (q_tens_s == 4'd0) ? SEG_BLANK : seg_q_tens_s;
    assign disp_r_tens_s = (r_tens_s == 4'd0) ? SEG_BLANK : seg_r_tens_s;
`else
    assign disp_q_tens_s = seg_q_tens_s;
    assign disp_r_tens_s = seg_r_tens_s;
`endif

    // Next-state, datapath and output-register update.
    always_comb begin
        state_s   = state_r;
        q_sr_s    = q_sr_r;
        r_sr_s    = r_sr_r;
        count_s   = count_r;
        hex0_s    = HEX0;
        hex1_s    = HEX1;
        hex2_s    = HEX2;
        hex3_s    = HEX3;
        overrun_s = Overrun;
        busy_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (InValid) begin
                    q_sr_s  = {{BCD_W{1'b0}}, Quotient};
                    r_sr_s  = {{BCD_W{1'b0}}, Remainder};
                    count_s = 3'(WIDTH);
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // Count reaching zero costs one settle cycle before UPDATE.
                if (count_r != 3'd0) begin
                    q_sr_s  = dabble_step(q_sr_r);
                    r_sr_s  = dabble_step(r_sr_r);
                    count_s = count_r - 3'd1;
                end else begin
                    state_s = UPDATE;
                end
            end
            UPDATE: begin
                hex0_s  = seg_q_ones_s;
                hex1_s  = disp_q_tens_s;
                hex2_s  = seg_r_ones_s;
                hex3_s  = disp_r_tens_s;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (InValid && Busy) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = Overrun;
        end

        if (state_s != IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State, shift registers and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            q_sr_r  <= {SR_W{1'b0}};
            r_sr_r  <= {SR_W{1'b0}};
            count_r <= 3'd0;
            Busy    <= 1'b0;
            Overrun <= 1'b0;
            HEX0    <= SEG_BLANK;
            HEX1    <= SEG_BLANK;
            HEX2    <= SEG_BLANK;
            HEX3    <= SEG_BLANK;
        end else begin
            state_r <= state_s;
            q_sr_r  <= q_sr_s;
            r_sr_r  <= r_sr_s;
            count_r <= count_s;
            Busy    <= busy_s;
            Overrun <= overrun_s;
            HEX0    <= hex0_s;
            HEX1    <= hex1_s;
            HEX2    <= hex2_s;
            HEX3    <= hex3_s;
        end
    end

endmodule

// File: tb/tb_div_result_display.sv
// Self-checking bench for div_result_display (WIDTH=4): vector table, corner
// sequences, exhaustive sweep and random conversions against a decimal model.
module tb_div_result_display;

    localparam int LAT = 6;

`ifdef DIV_DISPLAY_LEADING_BLANK_EN
    localparam bit LEAD_BLANK = 1'b1;
`else
    localparam bit LEAD_BLANK = 1'b0;
`endif

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ZT    = LEAD_BLANK ? 7'b1111111 : 7'b1000000;

    logic       Clock, Reset, InValid, Busy, Overrun;
    logic [3:0] Quotient, Remainder;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] pat [10];

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic [6:0] h0;
        logic [6:0] h1;
        logic [6:0] h2;
        logic [6:0] h3;
    } vec_t;

    vec_t vecs [5];

    div_result_display #(.WIDTH(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Overrun  (Overrun),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Decimal model: {tens pattern, ones pattern} of a value 0..99.
    function automatic logic [13:0] model_pair(input int v);
        logic [6:0] tens, ones;
        ones = pat[v % 10];
        tens = pat[v / 10];
        if (LEAD_BLANK && (v < 10)) tens = BLANK;
        return {tens, ones};
    endfunction

    function automatic logic [27:0] model_hex(input int q, input int r);
        return {model_pair(r), model_pair(q)};
    endfunction

    // Caller sits at a negedge with Busy low; strobes one request and waits it out.
    task automatic run_conv(input logic [3:0] q, input logic [3:0] r,
                            input logic [27:0] exp_hex, input string tag);
        int n;
        InValid   = 1'b1;
        Quotient  = q;
        Remainder = r;
        @(negedge Clock);
        InValid   = 1'b0;
        Quotient  = 4'($urandom);
        Remainder = 4'($urandom);
        n = 0;
        while (Busy && (n < 20)) begin
            @(negedge Clock);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(LAT));
        check({tag, " hex"}, {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, exp_hex});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy && (n < 20)) begin
            @(negedge Clock);
            n++;
        end
        check({tag, " idle reached"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        vecs[0] = '{q: 4'd13, r: 4'd2,  h0: 7'b0110000, h1: 7'b1111001, h2: 7'b0100100, h3: ZT};
        vecs[1] = '{q: 4'd15, r: 4'd0,  h0: 7'b0010010, h1: 7'b1111001, h2: 7'b1000000, h3: ZT};
        vecs[2] = '{q: 4'd0,  r: 4'd9,  h0: 7'b1000000, h1: ZT,         h2: 7'b0010000, h3: ZT};
        vecs[3] = '{q: 4'd10, r: 4'd15, h0: 7'b1000000, h1: 7'b1111001, h2: 7'b0010010, h3: 7'b1111001};
        vecs[4] = '{q: 4'd7,  r: 4'd3,  h0: 7'b1111000, h1: ZT,         h2: 7'b0110000, h3: ZT};

        Reset = 1'b1; InValid = 1'b0; Quotient = 4'd0; Remainder = 4'd0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, {4{BLANK}}});
        check("reset busy", 32'(Busy), 32'd0);
        check("reset overrun", 32'(Overrun), 32'd0);

        // Back-to-back: each request strobed in the cycle Busy reads low again.
        for (int i = 0; i < 5; i++) begin
            run_conv(vecs[i].q, vecs[i].r, {vecs[i].h3, vecs[i].h2, vecs[i].h1, vecs[i].h0},
                     $sformatf("vec%0d", i));
        end
        check("b2b overrun", 32'(Overrun), 32'd0);

        // Two strobes during one conversion are dropped and flag Overrun.
        InValid = 1'b1; Quotient = 4'd4; Remainder = 4'd11;
        @(negedge Clock);
        InValid = 1'b0;
        @(negedge Clock);
        InValid = 1'b1; Quotient = 4'd9; Remainder = 4'd1;
        @(negedge Clock);
        InValid = 1'b0;
        @(negedge Clock);
        InValid = 1'b1; Quotient = 4'd2; Remainder = 4'd5;
        @(negedge Clock);
        InValid = 1'b0;
        wait_idle("ovr");
        check("ovr hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, model_hex(4, 11)});
        check("ovr flag", 32'(Overrun), 32'd1);
        repeat (3) @(negedge Clock);
        check("ovr idle busy", 32'(Busy), 32'd0);
        run_conv(4'd12, 4'd6, model_hex(12, 6), "after ovr");
        check("ovr sticky", 32'(Overrun), 32'd1);

        // Reset during SHIFT step 2 blanks outputs at once.
        InValid = 1'b1; Quotient = 4'd9; Remainder = 4'd14;
        @(negedge Clock);
        InValid = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("midreset hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, {4{BLANK}}});
        check("midreset busy", 32'(Busy), 32'd0);
        check("midreset overrun", 32'(Overrun), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        run_conv(4'd7, 4'd3, model_hex(7, 3), "post reset");

        for (int q = 0; q < 16; q++) begin
            for (int r = 0; r < 16; r++) begin
                run_conv(4'(q), 4'(r), model_hex(q, r), $sformatf("sweep q%0d r%0d", q, r));
            end
        end

        for (int i = 0; i < 30; i++) begin
            int q, r, gap;
            q   = int'($urandom_range(0, 15));
            r   = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge Clock);
            run_conv(4'(q), 4'(r), model_hex(q, r), $sformatf("rand%0d", i));
        end
        check("final overrun", 32'(Overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
